// File: rtl/sel_access_ctrl.sv
// sel_access_ctrl
// Sequencer and arbiter for the select register and the memory access behind
// it. Grants one of panel / PU / IO, issues the one-hot load strobe that makes
// the select register capture the chosen address source, then runs the memory
// read/write handshake and reports completion (or timeout) to the requester.
//
// Ports:
//   clk, resetn            clock, asynchronous active-low reset
//   pnl_req                panel manual address load request
//   pu_req, pu_src, pu_we  PU access request, address source, write flag
//   io_req, io_we          IO access request (always addr2), write flag
//   do_*_to_sel*           one-hot select register load strobes
//   mem_rd, mem_wr, mem_ack memory handshake
//   pnl_done, pu_done, io_done  one-cycle completion pulses
//   err_timeout            pulses with the done pulse when the access aborted
//   busy                   high in every state except IDLE
//   state_dbg              current FSM state encoding
//
// Handshake: a requester raises *_req and holds it until its *_done pulse.
// Requests are sampled only in IDLE; a req still high in the IDLE cycle after
// done is a new request. mem_rd/mem_wr are held until mem_ack is sampled high
// in ACCESS or the timeout expires; mem_ack outside ACCESS is ignored.
module sel_access_ctrl #(
  parameter int MEM_TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       pnl_req,
  input  logic       pu_req,
  input  logic [1:0] pu_src,
  input  logic       pu_we,
  input  logic       io_req,
  input  logic       io_we,
  output logic       do_arr_sel_to_sel,
  output logic       do_strt_to_sel,
  output logic       do_addr1_to_sel,
  output logic       do_addr2_to_sel_pu,
  output logic       do_addr2_to_sel_io,
  output logic       mem_rd,
  output logic       mem_wr,
  input  logic       mem_ack,
  output logic       pnl_done,
  output logic       pu_done,
  output logic       io_done,
  output logic       err_timeout,
  output logic       busy,
  output logic [2:0] state_dbg
);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_SETTLE, S_ACCESS, S_DONE
  } state_t;

  typedef enum logic [1:0] {G_PNL, G_PU, G_IO} grant_t;

  localparam logic [7:0] TIMEOUT = 8'(MEM_TIMEOUT);

  state_t     state, state_n;
  grant_t     grant, grant_n;
  logic [1:0] src, src_n;
  logic       we, we_n;
  logic       last_io, last_io_n;   // 1: last PU/IO grant went to IO
  logic [7:0] cnt, cnt_n;
  logic       err, err_n;

  // Next values of the registered (Moore) outputs.
  logic [4:0] strb_n;   // {arr, strt, addr1, addr2_pu, addr2_io}
  logic       rd_n, wr_n, pnl_done_n, pu_done_n, io_done_n, err_to_n, busy_n;

  always_comb begin
    state_n   = state;
    grant_n   = grant;
    src_n     = src;
    we_n      = we;
    last_io_n = last_io;
    cnt_n     = cnt;
    err_n     = err;
    unique case (state)
      S_IDLE: begin
        cnt_n = '0;
        err_n = 1'b0;
        if (pnl_req) begin
          grant_n = G_PNL;
          state_n = S_LOAD;
        end else if (pu_req && (!io_req || last_io)) begin
          grant_n   = G_PU;
          src_n     = pu_src;
          we_n      = pu_we;
          last_io_n = 1'b0;
          // Source 3 keeps the current select value: skip load and settle.
          state_n   = (pu_src == 2'd3) ? S_ACCESS : S_LOAD;
        end else if (io_req) begin
          grant_n   = G_IO;
          src_n     = 2'd2;
          we_n      = io_we;
          last_io_n = 1'b1;
          state_n   = S_LOAD;
        end
      end
      S_LOAD:   state_n = (grant == G_PNL) ? S_DONE : S_SETTLE;
      S_SETTLE: state_n = S_ACCESS;
      S_ACCESS: begin
        cnt_n = cnt + 8'd1;
        // Ack has precedence over a timeout expiring in the same cycle.
        if (mem_ack) begin
          state_n = S_DONE;
        end else if (cnt_n == TIMEOUT) begin
          state_n = S_DONE;
          err_n   = 1'b1;
        end
      end
      S_DONE: begin
        cnt_n   = '0;
        state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  // Outputs are a function of the state being entered, then registered.
  always_comb begin
    strb_n = '0;
    if (state_n == S_LOAD) begin
      unique case (grant_n)
        G_PNL:   strb_n = 5'b10000;
        G_IO:    strb_n = 5'b00001;
        default: begin
          unique case (src_n)
            2'd0:    strb_n = 5'b01000;
            2'd1:    strb_n = 5'b00100;
            2'd2:    strb_n = 5'b00010;
            default: strb_n = 5'b00000;
          endcase
        end
      endcase
    end
    rd_n       = (state_n == S_ACCESS) && !we_n;
    wr_n       = (state_n == S_ACCESS) &&  we_n;
    pnl_done_n = (state_n == S_DONE) && (grant_n == G_PNL);
    pu_done_n  = (state_n == S_DONE) && (grant_n == G_PU);
    io_done_n  = (state_n == S_DONE) && (grant_n == G_IO);
    err_to_n   = (state_n == S_DONE) && err_n;
    busy_n     = (state_n != S_IDLE);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state              <= S_IDLE;
      grant              <= G_IO;
      src                <= '0;
      we                 <= 1'b0;
      last_io            <= 1'b1;
      cnt                <= '0;
      err                <= 1'b0;
      do_arr_sel_to_sel  <= 1'b0;
      do_strt_to_sel     <= 1'b0;
      do_addr1_to_sel    <= 1'b0;
      do_addr2_to_sel_pu <= 1'b0;
      do_addr2_to_sel_io <= 1'b0;
      mem_rd             <= 1'b0;
      mem_wr             <= 1'b0;
      pnl_done           <= 1'b0;
      pu_done            <= 1'b0;
      io_done            <= 1'b0;
      err_timeout        <= 1'b0;
      busy               <= 1'b0;
    end else begin
      state              <= state_n;
      grant              <= grant_n;
      src                <= src_n;
      we                 <= we_n;
      last_io            <= last_io_n;
      cnt                <= cnt_n;
      err                <= err_n;
      do_arr_sel_to_sel  <= strb_n[4];
      do_strt_to_sel     <= strb_n[3];
      do_addr1_to_sel    <= strb_n[2];
      do_addr2_to_sel_pu <= strb_n[1];
      do_addr2_to_sel_io <= strb_n[0];
      mem_rd             <= rd_n;
      mem_wr             <= wr_n;
      pnl_done           <= pnl_done_n;
      pu_done            <= pu_done_n;
      io_done            <= io_done_n;
      err_timeout        <= err_to_n;
      busy               <= busy_n;
    end
  end

  assign state_dbg = state;

endmodule

// File: tb/tb_sel_access_ctrl.sv
// Bench for sel_access_ctrl. Each transaction is predicted as a timeline of
// output vectors (strobe cycle, settle cycle, N access cycles, done cycle)
// derived from the arbitration and timing rules, then compared cycle by cycle.
module tb_sel_access_ctrl;

  localparam int TO = 15;

  // Output vector bit masks.
  localparam logic [11:0] B_ARR  = 12'h800, B_STRT = 12'h400, B_A1  = 12'h200,
                          B_A2PU = 12'h100, B_A2IO = 12'h080, B_RD  = 12'h040,
                          B_WR   = 12'h020, B_PND  = 12'h010, B_PUD = 12'h008,
                          B_IOD  = 12'h004, B_ERR  = 12'h002, B_BUSY = 12'h001;

  logic       clk = 1'b0;
  logic       resetn;
  logic       pnl_req, pu_req, pu_we, io_req, io_we, mem_ack;
  logic [1:0] pu_src;
  logic       do_arr_sel_to_sel, do_strt_to_sel, do_addr1_to_sel;
  logic       do_addr2_to_sel_pu, do_addr2_to_sel_io;
  logic       mem_rd, mem_wr, pnl_done, pu_done, io_done, err_timeout, busy;
  logic [2:0] state_dbg;

  int checks   = 0;
  int failures = 0;
  bit m_last_io;     // model: last PU/IO grant went to IO

  sel_access_ctrl #(.MEM_TIMEOUT(TO)) dut (
    .clk(clk), .resetn(resetn),
    .pnl_req(pnl_req), .pu_req(pu_req), .pu_src(pu_src), .pu_we(pu_we),
    .io_req(io_req), .io_we(io_we),
    .do_arr_sel_to_sel(do_arr_sel_to_sel), .do_strt_to_sel(do_strt_to_sel),
    .do_addr1_to_sel(do_addr1_to_sel), .do_addr2_to_sel_pu(do_addr2_to_sel_pu),
    .do_addr2_to_sel_io(do_addr2_to_sel_io),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_ack(mem_ack),
    .pnl_done(pnl_done), .pu_done(pu_done), .io_done(io_done),
    .err_timeout(err_timeout), .busy(busy), .state_dbg(state_dbg)
  );

  // Clock
  always #5 clk = ~clk;

  function automatic logic [11:0] obs();
    return {do_arr_sel_to_sel, do_strt_to_sel, do_addr1_to_sel,
            do_addr2_to_sel_pu, do_addr2_to_sel_io, mem_rd, mem_wr,
            pnl_done, pu_done, io_done, err_timeout, busy};
  endfunction

  task automatic check(input string tag, input logic [11:0] o,
                       input logic [11:0] e);
    checks++;
    assert (o === e) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, o, e);
    end
  endtask

  // Run one transaction from IDLE. ack_at: access cycle (1-based) in which
  // mem_ack is driven high; 0 means never.
  task automatic run_txn(input bit pnl, input bit pu, input bit io,
                         input logic [1:0] src, input bit pwe, input bit iwe,
                         input int ack_at, input string tag);
    logic [11:0] exp_q[$];
    int          acc_q[$];
    int          w, n, k;
    bit          wr, tmo;
    logic [11:0] strobe;
    // Arbitration: panel first, then round robin between PU and IO.
    if (pnl) w = 1;
    else if (pu && (!io || m_last_io)) w = 2;
    else w = 3;
    if (w == 2) m_last_io = 1'b0;
    if (w == 3) m_last_io = 1'b1;
    // Expected timeline.
    if (w == 1) begin
      exp_q.push_back(B_ARR | B_BUSY); acc_q.push_back(0);
      exp_q.push_back(B_PND | B_BUSY); acc_q.push_back(0);
    end else begin
      if (!(w == 2 && src == 2'd3)) begin
        if (w == 3)           strobe = B_A2IO;
        else if (src == 2'd0) strobe = B_STRT;
        else if (src == 2'd1) strobe = B_A1;
        else                  strobe = B_A2PU;
        exp_q.push_back(strobe | B_BUSY); acc_q.push_back(0);
        exp_q.push_back(B_BUSY);          acc_q.push_back(0);
      end
      wr  = (w == 2) ? pwe : iwe;
      tmo = !(ack_at >= 1 && ack_at <= TO);
      n   = tmo ? TO : ack_at;
      for (int i = 1; i <= n; i++) begin
        exp_q.push_back((wr ? B_WR : B_RD) | B_BUSY); acc_q.push_back(i);
      end
      exp_q.push_back(((w == 2) ? B_PUD : B_IOD) | (tmo ? B_ERR : 12'h000) | B_BUSY);
      acc_q.push_back(0);
    end
    // Drive the request during the IDLE cycle.
    pnl_req = pnl; pu_req = pu; io_req = io;
    pu_src = src; pu_we = pwe; io_we = iwe;
    mem_ack = 1'($urandom_range(0, 1));
    while (exp_q.size() > 0) begin
      @(posedge clk); #1;
      k = acc_q.pop_front();
      check(tag, obs(), exp_q.pop_front());
      // Ack only where planned inside ACCESS; noise elsewhere must be ignored.
      mem_ack = (k != 0) ? (k == ack_at) : 1'($urandom_range(0, 1));
      // Latched fields must ignore post-grant changes.
      pu_src = 2'($urandom_range(0, 3));
      pu_we  = 1'($urandom_range(0, 1));
      io_we  = 1'($urandom_range(0, 1));
    end
    pnl_req = 1'b0; pu_req = 1'b0; io_req = 1'b0;
    @(posedge clk); #1;
    check({tag, "_idle"}, obs(), 12'h000);
  endtask

  initial begin
    int ack;
    bit p, u, o;
    // Clock / reset
    resetn = 1'b0;
    pnl_req = 0; pu_req = 0; pu_src = 0; pu_we = 0; io_req = 0; io_we = 0;
    mem_ack = 0;
    m_last_io = 1'b1;
    repeat (3) @(posedge clk);
    #1 check("reset_outputs", obs(), 12'h000);
    @(negedge clk); resetn = 1'b1;
    @(posedge clk); #1;
    check("post_reset_idle", obs(), 12'h000);

    // Directed steps.
    run_txn(0, 1, 0, 2'd1, 0, 0, 1,  "pu_addr1_read");
    run_txn(0, 1, 1, 2'd2, 0, 0, 1,  "rr_1");
    run_txn(0, 1, 1, 2'd2, 1, 0, 1,  "rr_2");
    run_txn(0, 1, 1, 2'd0, 0, 1, 1,  "rr_3");
    run_txn(0, 1, 1, 2'd1, 1, 1, 1,  "rr_4");
    run_txn(1, 1, 1, 2'd1, 0, 0, 1,  "pnl_prio");
    run_txn(0, 1, 1, 2'd1, 0, 0, 1,  "pu_after_pnl");
    run_txn(0, 0, 1, 2'd0, 0, 1, 0,  "io_wr_timeout");
    run_txn(0, 1, 0, 2'd3, 0, 0, 1,  "pu_src3");
    run_txn(0, 1, 0, 2'd3, 1, 0, TO, "ack_at_timeout");

    // Reset in the middle of an access.
    pu_req = 1; pu_src = 2'd1; pu_we = 0; mem_ack = 0;
    repeat (3) @(posedge clk);
    #1 check("pre_reset_access", obs(), B_RD | B_BUSY);
    #2 resetn = 1'b0;
    #1 check("async_reset_drop", obs(), 12'h000);
    pu_req = 0;
    #2 resetn = 1'b1;
    m_last_io = 1'b1;
    @(posedge clk); #1;
    check("after_reset_no_done", obs(), 12'h000);
    run_txn(0, 1, 0, 2'd2, 1, 0, 2,  "pu_after_reset");

    // Randomized transactions.
    for (int t = 0; t < 40; t++) begin
      p = ($urandom_range(0, 4) == 0);
      u = 1'($urandom_range(0, 1));
      o = 1'($urandom_range(0, 1));
      if (!p && !u && !o) u = 1'b1;
      ack = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 5);
      run_txn(p, u, o, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 1)), ack, "random");
    end

    // Final report
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
